// File: rtl/counter_pkg.sv
// Shared types and helpers for the run-controlled modulo counter.
package counter_pkg;

  localparam int unsigned CNT_WIDTH  = 4;
  localparam int unsigned CNT_WRAP_W = 8;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_e;

  // Effective period: a programmed modulus of 0 stands for 2^w.
  function automatic logic [32:0] eff_modulus(input logic [31:0] m, input int unsigned w);
    if (m == 32'd0) return 33'd1 << w;
    return {1'b0, m};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Programmable modulo counter with run control, one-shot mode and wrap count.
// Optional up/down counting is enabled by defining MOD_COUNTER_UPDOWN_EN.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = CNT_WIDTH,
  parameter int unsigned WRAP_W = CNT_WRAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              oneshot,
  input  logic              en,
  input  logic [WIDTH-1:0]  modulus,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
`ifdef MOD_COUNTER_UPDOWN_EN
  input  logic              dir,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps,
  output logic              busy,
  output logic              done
);

  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] modulus_q, modulus_d;
  logic             oneshot_q, oneshot_d;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             wrap_clr, wrap_inc;

  logic [WIDTH-1:0] last_run;
  logic [WIDTH-1:0] start_run, term_run, start_new, stepped;

  assign last_run = WIDTH'(eff_modulus(32'(modulus_q), WIDTH) - 33'd1);

`ifdef MOD_COUNTER_UPDOWN_EN
  logic [WIDTH-1:0] last_new;
  assign last_new  = WIDTH'(eff_modulus(32'(modulus), WIDTH) - 33'd1);
  assign start_run = dir ? last_run : '0;
  assign term_run  = dir ? '0 : last_run;
  assign start_new = dir ? last_new : '0;
  assign stepped   = dir ? count - WIDTH'(1) : count + WIDTH'(1);
`else
  assign start_run = '0;
  assign term_run  = last_run;
  assign start_new = '0;
  assign stepped   = count + WIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CNT_IDLE;
      modulus_q <= '0;
      oneshot_q <= 1'b0;
      count     <= '0;
      tc        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      modulus_q <= modulus_d;
      oneshot_q <= oneshot_d;
      count     <= count_d;
      tc        <= tc_d;
      busy      <= (state_d == CNT_RUN);
      done      <= (state_d == CNT_DONE);
    end
  end

  // Next state and datapath; priority stop > start > load > en inside RUN.
  always_comb begin
    state_d   = state_q;
    modulus_d = modulus_q;
    oneshot_d = oneshot_q;
    count_d   = count;
    tc_d      = 1'b0;
    wrap_clr  = 1'b0;
    wrap_inc  = 1'b0;
    case (state_q)
      CNT_IDLE, CNT_DONE: begin
        if (start) begin
          state_d   = CNT_RUN;
          modulus_d = modulus;
          oneshot_d = oneshot;
          count_d   = start_new;
          wrap_clr  = 1'b1;
        end
      end
      CNT_RUN: begin
        if (stop) begin
          state_d = CNT_IDLE;
        end else if (start) begin
          modulus_d = modulus;
          oneshot_d = oneshot;
          count_d   = start_new;
          wrap_clr  = 1'b1;
        end else if (load) begin
          count_d = load_val;
        end else if (en) begin
          if (count == term_run) begin
            tc_d     = 1'b1;
            wrap_inc = 1'b1;
            if (oneshot_q) begin
              state_d = CNT_DONE;
            end else begin
              count_d = start_run;
            end
          end else begin
            count_d = stepped;
          end
        end
      end
      default: state_d = CNT_IDLE;
    endcase
  end

  sat_counter #(.W(WRAP_W)) u_wraps (
    .clk   (clk),
    .rst   (rst),
    .clr   (wrap_clr),
    .inc   (wrap_inc),
    .value (wraps)
  );

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter; a second instance with WRAP_W=2 covers saturation.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, start, stop, oneshot, en, load;
  logic [3:0] modulus, load_val;
`ifdef MOD_COUNTER_UPDOWN_EN
  logic       dir;
`endif
  logic [3:0] count, count_s;
  logic       tc, tc_s, busy, busy_s, done, done_s;
  logic [7:0] wraps;
  logic [1:0] wraps_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .WRAP_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot), .en(en),
    .modulus(modulus), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_UPDOWN_EN
    .dir(dir),
`endif
    .count(count), .tc(tc), .wraps(wraps), .busy(busy), .done(done)
  );

  mod_counter #(.WIDTH(4), .WRAP_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot), .en(en),
    .modulus(modulus), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_UPDOWN_EN
    .dir(dir),
`endif
    .count(count_s), .tc(tc_s), .wraps(wraps_s), .busy(busy_s), .done(done_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input logic os);
    modulus = 4'(n);
    oneshot = os;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0; en = 1'b0;
    load = 1'b0; modulus = 4'd0; load_val = 4'd0;
`ifdef MOD_COUNTER_UPDOWN_EN
    dir = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    check("rst_count", int'(count), 0);
    check("rst_tc", int'(tc), 0);
    check("rst_wraps", int'(wraps), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    // Continuous N=10
    en = 1'b1;
    do_start(10, 1'b0);
    check("n10_start_busy", int'(busy), 1);
    check("n10_start_count", int'(count), 0);
    check("n10_start_tc", int'(tc), 0);
    for (int i = 1; i <= 30; i++) begin
      step();
      check($sformatf("n10_count_%0d", i), int'(count), i % 10);
      check($sformatf("n10_tc_%0d", i), int'(tc), (i % 10 == 0) ? 1 : 0);
    end
    check("n10_wraps", int'(wraps), 3);
    en = 1'b0;
    step();
    check("en0_count", int'(count), 0);
    check("en0_tc", int'(tc), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_wraps_hold", int'(wraps), 3);

    // One-shot N=4
    en = 1'b1;
    do_start(4, 1'b1);
    check("os_wraps_clr", int'(wraps), 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("os_count_%0d", i), int'(count), i);
      check($sformatf("os_busy_%0d", i), int'(busy), 1);
    end
    step();
    check("os_done", int'(done), 1);
    check("os_busy", int'(busy), 0);
    check("os_count_hold", int'(count), 3);
    check("os_tc", int'(tc), 1);
    check("os_wraps", int'(wraps), 1);
    step();
    step();
    check("os_after_tc", int'(tc), 0);
    check("os_after_count", int'(count), 3);
    check("os_after_done", int'(done), 1);

    // N=1: tc every enabled cycle
    do_start(1, 1'b0);
    check("n1_busy", int'(busy), 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("n1_count_%0d", i), int'(count), 0);
      check($sformatf("n1_tc_%0d", i), int'(tc), 1);
    end
    check("n1_wraps", int'(wraps), 3);

    // N=0 means 16
    do_start(0, 1'b0);
    check("n0_start_count", int'(count), 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("n0_count_%0d", i), int'(count), i % 16);
      check($sformatf("n0_tc_%0d", i), int'(tc), (i == 16) ? 1 : 0);
    end

    // stop+load+en together at count 5
    do_start(10, 1'b0);
    repeat (5) step();
    check("sim_pre_count", int'(count), 5);
    stop = 1'b1; load = 1'b1; load_val = 4'd8;
    step();
    stop = 1'b0; load = 1'b0;
    check("sim_stop_busy", int'(busy), 0);
    check("sim_stop_count", int'(count), 5);
    check("sim_stop_tc", int'(tc), 0);

    // load+en at count 5
    do_start(10, 1'b0);
    repeat (5) step();
    load = 1'b1; load_val = 4'd8;
    step();
    load = 1'b0;
    check("load_count", int'(count), 8);
    check("load_tc", int'(tc), 0);
    step();
    check("load_next", int'(count), 9);
    step();
    check("load_wrap_count", int'(count), 0);
    check("load_wrap_tc", int'(tc), 1);

    // Mid-run reset at count 7
    do_start(10, 1'b0);
    repeat (7) step();
    check("mrst_pre", int'(count), 7);
    rst = 1'b1; start = 1'b1; load = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; load = 1'b0;
    check("mrst_count", int'(count), 0);
    check("mrst_tc", int'(tc), 0);
    check("mrst_wraps", int'(wraps), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);

    // Wrap saturation, N=2
    do_start(2, 1'b0);
    repeat (6) step();
    check("sat_wraps3", int'(wraps_s), 3);
    repeat (4) step();
    check("sat_wraps_stick", int'(wraps_s), 3);
    check("sat_wide_wraps", int'(wraps), 5);

`ifdef MOD_COUNTER_UPDOWN_EN
    // Down counting N=5, then flip direction at count 2
    dir = 1'b1;
    do_start(5, 1'b0);
    check("dn_start", int'(count), 4);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("dn_count_%0d", i), int'(count), (i == 5) ? 4 : 4 - i);
      check($sformatf("dn_tc_%0d", i), int'(tc), (i == 5) ? 1 : 0);
    end
    step();
    step();
    check("dn_at2", int'(count), 2);
    dir = 1'b0;
    step();
    check("flip_up", int'(count), 3);
    step();
    check("flip_up4", int'(count), 4);
    check("flip_up4_tc", int'(tc), 0);
    step();
    check("flip_wrap", int'(count), 0);
    check("flip_wrap_tc", int'(tc), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised, run-controlled modulo counter: the next generation of the team's fixed divide-by-10 counter. It adds a runtime-programmable modulus, start/stop control, one-shot and continuous modes, synchronous load and a saturating wrap counter. It sits in the timer/prescaler layer and drives periodic strobes (`tc`) to datapath and test logic.

## Interface
- `WIDTH`, 4: count register width.
- `WRAP_W`, 8: wrap-counter width.
- `clk  in  1`: sole clock, all state on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: begin counting; latches `modulus` and `oneshot`.
- `stop  in  1`: abort run and return to IDLE.
- `oneshot  in  1`: 1 = stop after first wrap; 0 = continuous.
- `en  in  1`: count enable (tick qualifier) while running.
- `modulus  in  WIDTH`: period N. 0 means 2^WIDTH.
- `load  in  1`: synchronous load of `count` from `load_val` while running.
- `load_val  in  WIDTH`: load value, must be below the latched modulus.
- `dir  in  1`: 0 = up, 1 = down. Present only with `MOD_COUNTER_UPDOWN_EN`.
- `count  out  WIDTH`: current count.
- `tc  out  1`: registered one-cycle terminal-count pulse.
- `wraps  out  WRAP_W`: number of wraps since start, saturating.
- `busy  out  1`: high in RUN.
- `done  out  1`: high in DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE → RUN on `start`. DONE → RUN on `start`.
- RUN → DONE on a one-shot wrap.
- RUN → IDLE on `stop`.
- `start` in RUN restarts the run: count is set to its start value, `wraps` to 0, and `modulus`/`oneshot` are relatched.
- Start value is 0 when counting up and N−1 when counting down.
- Terminal value is N−1 when counting up and 0 when counting down.
- Each enabled RUN cycle: if count equals the terminal value, count wraps to the start value and `tc` is set high; otherwise count steps by ±1 and `tc` is set low.
- `tc` is low in every cycle without a wrap, including every cycle where `en`=0.
- N=1: count stays 0, and `tc` fires on every enabled cycle.
- N=0 is treated as 2^WIDTH. Arithmetic is modulo 2^WIDTH, with a natural overflow wrap.
- `wraps` increments on each wrap and saturates at 2^WRAP_W−1. It holds in IDLE and DONE and is cleared only by `start`.
- `load` in RUN: count takes `load_val` and `tc` is low that cycle. Loading a value ≥ N is illegal: the block does not clamp it, and the bench must not drive it.
- Priority, highest first: `rst` > `stop` > `start` > `load` > `en`.
- `load` and `en` are ignored outside RUN. `stop` is ignored outside RUN.
- In DONE, count holds its terminal value.

## Timing
- Every output is registered; there is no combinational path from inputs to outputs.
- Reset values: `count`=0, `tc`=0, `wraps`=0, `busy`=0, `done`=0.
- `start` at edge k: `busy`=1 and count = start value after edge k. The first enabled step happens at edge k+1.
- Wrap at edge k: `tc`=1 for exactly the cycle following edge k, in which count already shows the start value.
- One-shot wrap: the same edge that raises `tc` also sets `done`=1, `busy`=0, and holds count at the terminal value, not the start value.
- `rst` asserted mid-run forces reset values at the next edge, regardless of any other input.

## Configuration
- `MOD_COUNTER_UPDOWN_EN` defined: the `dir` port exists. `dir` is sampled every RUN cycle. A direction change takes effect on the next step; the current count is kept and the terminal check uses the new direction.
- `MOD_COUNTER_UPDOWN_EN` undefined: there is no `dir` port, counting is up-only, and the down-path logic is absent.

## Structure
- Package `counter_pkg` holds:
  - the FSM state enum (`CNT_IDLE`, `CNT_RUN`, `CNT_DONE`);
  - the default `WIDTH`/`WRAP_W` constants;
  - a helper function that maps `modulus` 0 to 2^WIDTH.
- One sub-module, `sat_counter`, implements the `wraps` saturating incrementer with clear.
- The FSM and the main count datapath stay in `mod_counter`.

## Test plan
- Reset, then `start` with N=10, continuous, `en`=1: count runs 0..9, 0. `tc` is high only in the cycle count returns to 0, every 10 cycles. `wraps` reads 3 after 30 enabled cycles.
- One-shot with N=4 and `en`=1: `done`=1 and `busy`=0 after the 4th enabled cycle. Count holds 3, `tc` pulses once, and further `en` has no effect.
- N=1, then N=0 with WIDTH=4: `tc` fires every enabled cycle for N=1. For N=0, the period is 16 and the wrap goes 15→0.
- Simultaneous events in RUN with count=5, N=10:
  - `stop`+`load`+`en` in the same cycle → IDLE, and count does not change.
  - `load_val`=8 with `load`+`en` → count=8 with no increment.
- Mid-run `rst` at count=7: every output equals its reset value at the next edge. `wraps` saturation: with WRAP_W=2 and N=2, `wraps` sticks at 3.
- With `MOD_COUNTER_UPDOWN_EN`, N=5, `dir`=1: count runs 4,3,2,1,0,4 and `tc` is high when 4 reappears. Flipping `dir` to 0 at count=2 gives 3 on the next step.
